// File: rtl/transposer_job_ctrl_pkg.sv
// Shared types for the transposer job sequencer.
//   job_desc_t  : one queued job (precision, MVU base address, word count)
//   tjc_state_e : sequencer states
//   desc_legal(): descriptor range check applied at the input port
package transposer_job_ctrl_pkg;

  typedef struct packed {
    logic [31:0] prec;
    logic [31:0] baddr;
    logic [31:0] nwords;
  } job_desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } tjc_state_e;

  // Legal when 1 <= prec <= max_prec and 1 <= nwords <= max_words.
  function automatic logic desc_legal(input logic [31:0] prec,
                                      input logic [31:0] nwords,
                                      input logic [31:0] max_prec,
                                      input logic [31:0] max_words);
    return (prec != 32'd0) && (prec <= max_prec) &&
           (nwords != 32'd0) && (nwords <= max_words);
  endfunction

endpackage

// File: rtl/transposer_job_fifo.sv
// Descriptor queue: synchronous FIFO of job_desc_t.
//   clk, rst   : clock, async active-high reset (empties the queue)
//   push, din  : write one descriptor (ignored when full)
//   pop, dout  : dout is the head; pop removes it (ignored when empty)
//   full, empty, count : occupancy
module transposer_job_fifo
  import transposer_job_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  job_desc_t                din,
  input  logic                     pop,
  output job_desc_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  job_desc_t       mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic            do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/transposer_job_ctrl.sv
// Job sequencer in front of data_transposer. Buffers a whole job's words, then
// streams them as one gap-free burst with tp_start high, waits for tp_busy to
// clear and pulses job_done.
//   job_*        : descriptor input (valid/ready), job_err flags rejected ones
//   in_*         : word stream input (valid/ready), accepted only in FILL
//   tp_*         : transposer interface (prec/baddr/iword/start out, busy in)
//   job_done     : one-cycle pulse per completed job
//   jobs_pending : queued descriptors plus one for the active job
// Optional macro TRANSPOSER_JOB_CTRL_PERF_EN adds perf_fill_stall and
// perf_drain_cyc saturating counters.
module transposer_job_ctrl
  import transposer_job_ctrl_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MVU_ADDR_LEN  = 15,
  parameter int MAX_DATA_PREC = 8,
  parameter int WBUF_DEPTH    = 64,
  parameter int JOBQ_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [31:0]                   job_prec,
  input  logic [31:0]                   job_baddr,
  input  logic [$clog2(WBUF_DEPTH):0]   job_nwords,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [XLEN-1:0]               in_word,
  output logic [31:0]                   tp_prec,
  output logic [31:0]                   tp_baddr,
  output logic [XLEN-1:0]               tp_iword,
  output logic                          tp_start,
  input  logic                          tp_busy,
  output logic                          job_done,
  output logic                          job_err,
`ifdef TRANSPOSER_JOB_CTRL_PERF_EN
  output logic [31:0]                   perf_fill_stall,
  output logic [31:0]                   perf_drain_cyc,
`endif
  output logic [$clog2(JOBQ_DEPTH):0]   jobs_pending
);
  localparam int AW = $clog2(WBUF_DEPTH);
  localparam int NW = AW + 1;
  localparam int QW = $clog2(JOBQ_DEPTH) + 1;

  tjc_state_e      state, nxt;
  job_desc_t       q_in, q_head;
  logic            q_full, q_empty, q_push, q_pop;
  logic [QW-1:0]   q_count;
  logic            legal, wr_en, last_rd;
  logic [NW-1:0]   cur_nw, cnt, rd;
  logic [1:0]      dwait;
  logic [XLEN-1:0] wbuf [WBUF_DEPTH];

  // baddr is forwarded at full port width; upper nwords bits are always zero
  // for legal descriptors.
  logic unused_bits;
  assign unused_bits = ^{q_head.nwords[31:NW], 1'(MVU_ADDR_LEN)};

  assign legal = desc_legal(job_prec, 32'(job_nwords),
                            32'(MAX_DATA_PREC), 32'(WBUF_DEPTH));
  // Ready reflects occupancy before any same-cycle pop.
  assign job_ready = !q_full && !rst;
  assign q_push    = job_valid && job_ready && legal;
  assign q_in      = '{prec: job_prec, baddr: job_baddr, nwords: 32'(job_nwords)};

  transposer_job_fifo #(.DEPTH(JOBQ_DEPTH)) u_jobq (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .din   (q_in),
    .pop   (q_pop),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign wr_en        = in_valid && in_ready;
  assign last_rd      = (rd == cur_nw - NW'(1));
  assign tp_iword     = (state == S_STREAM) ? wbuf[rd[AW-1:0]] : '0;
  assign jobs_pending = q_count + QW'(state != S_IDLE);

  always_comb begin
    nxt      = state;
    q_pop    = 1'b0;
    in_ready = 1'b0;
    tp_start = 1'b0;
    job_done = 1'b0;
    case (state)
      S_IDLE: if (!q_empty) begin q_pop = 1'b1; nxt = S_FILL; end
      S_FILL: begin
        in_ready = (cnt < cur_nw);
        // Leave on the last accept so the burst starts the next cycle.
        if (wr_en && (cnt + NW'(1) == cur_nw)) nxt = S_STREAM;
      end
      S_STREAM: begin
        tp_start = 1'b1;
        if (last_rd) nxt = S_DRAIN;
      end
      // dwait reaches 2 two cycles after tp_start falls, masking busy lag.
      S_DRAIN: if (dwait == 2'd2 && !tp_busy) nxt = S_DONE;
      S_DONE: begin
        job_done = 1'b1;
        // Pop here so a queued job enters FILL right after DONE.
        if (!q_empty) begin q_pop = 1'b1; nxt = S_FILL; end
        else nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tp_prec  <= '0;
      tp_baddr <= '0;
      cur_nw   <= '0;
      cnt      <= '0;
      rd       <= '0;
      dwait    <= '0;
      job_err  <= 1'b0;
    end else begin
      state   <= nxt;
      job_err <= job_valid && job_ready && !legal;
      if (q_pop) begin
        tp_prec  <= q_head.prec;
        tp_baddr <= q_head.baddr;
        cur_nw   <= q_head.nwords[NW-1:0];
        cnt      <= '0;
        rd       <= '0;
      end else begin
        if (wr_en)              cnt <= cnt + NW'(1);
        if (state == S_STREAM)  rd  <= rd + NW'(1);
      end
      if (state != S_DRAIN)     dwait <= '0;
      else if (dwait != 2'd2)   dwait <= dwait + 2'd1;
    end
  end

  always_ff @(posedge clk)
    if (wr_en) wbuf[cnt[AW-1:0]] <= in_word;

`ifdef TRANSPOSER_JOB_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fill_stall <= '0;
      perf_drain_cyc  <= '0;
    end else begin
      if (state == S_FILL && !in_valid && perf_fill_stall != '1)
        perf_fill_stall <= perf_fill_stall + 32'd1;
      if (state == S_DRAIN && perf_drain_cyc != '1)
        perf_drain_cyc <= perf_drain_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_transposer_job_ctrl.sv
module tb_transposer_job_ctrl;
  logic        clk = 0, rst = 1;
  logic        job_valid = 0, job_ready;
  logic [31:0] job_prec = 0, job_baddr = 0;
  logic [6:0]  job_nwords = 0;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_word = 0;
  logic [31:0] tp_prec, tp_baddr, tp_iword;
  logic        tp_start, tp_busy = 0, job_done, job_err;
  logic [2:0]  jobs_pending;
`ifdef TRANSPOSER_JOB_CTRL_PERF_EN
  logic [31:0] perf_fill_stall, perf_drain_cyc;
`endif

  transposer_job_ctrl dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_prec(job_prec), .job_baddr(job_baddr), .job_nwords(job_nwords),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .tp_prec(tp_prec), .tp_baddr(tp_baddr), .tp_iword(tp_iword),
    .tp_start(tp_start), .tp_busy(tp_busy), .job_done(job_done),
    .job_err(job_err),
`ifdef TRANSPOSER_JOB_CTRL_PERF_EN
    .perf_fill_stall(perf_fill_stall), .perf_drain_cyc(perf_drain_cyc),
`endif
    .jobs_pending(jobs_pending)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int prec; int baddr; int nw; } mdesc_t;
  mdesc_t      mq[$];
  logic [31:0] m_words[$];
  bit          m_act, m_fill, m_strm, m_drain, m_done, m_err;
  int          m_prec, m_baddr, m_nw, m_idx, m_age;

  function automatic bit legal_f(int p, int n);
    return p >= 1 && p <= 8 && n >= 1 && n <= 64;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete(); m_words.delete();
      {m_act, m_fill, m_strm, m_drain, m_done, m_err} = '0;
      m_prec = 0; m_baddr = 0; m_nw = 0; m_idx = 0; m_age = 0;
    end else begin
      bit rdy, lg;
      int qn;
      rdy = mq.size() < 4;
      qn  = mq.size();
      lg  = legal_f(int'(job_prec), int'(job_nwords));
      if (m_done) begin m_done = 0; m_act = 0; end
      else if (m_fill) begin
        if (in_valid) m_words.push_back(in_word);
        if (m_words.size() == m_nw) begin m_fill = 0; m_strm = 1; m_idx = 0; end
      end else if (m_strm) begin
        m_idx++;
        if (m_idx == m_nw) begin m_strm = 0; m_drain = 1; m_age = 0; end
      end else if (m_drain) begin
        if (m_age >= 2 && !tp_busy) begin m_drain = 0; m_done = 1; end
        else m_age++;
      end
      if (!m_act && qn > 0) begin
        mdesc_t d;
        d = mq.pop_front();
        m_act = 1; m_fill = 1; m_words.delete();
        m_prec = d.prec; m_baddr = d.baddr; m_nw = d.nw;
      end
      if (job_valid && rdy && lg)
        mq.push_back('{prec: int'(job_prec), baddr: int'(job_baddr), nw: int'(job_nwords)});
      m_err = job_valid && rdy && !lg;
    end
  end

  // ---------------- compare + monitors ----------------
  int ir_cnt, st_cnt, st_runs, done_cnt, err_cnt, done_cyc;
  bit prev_st;
  logic [31:0] first_word;
  int done_precs[$];

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("job_ready", job_ready, mq.size() < 4);
      chk("in_ready", in_ready, m_fill && m_words.size() < m_nw);
      chk("tp_start", tp_start, m_strm);
      chk("tp_iword", tp_iword, m_strm ? m_words[m_idx] : 0);
      chk("tp_prec", tp_prec, m_prec);
      chk("tp_baddr", tp_baddr, m_baddr);
      chk("job_done", job_done, m_done);
      chk("job_err", job_err, m_err);
      chk("jobs_pending", jobs_pending, mq.size() + int'(m_act));
      ir_cnt += int'(in_ready);
      st_cnt += int'(tp_start);
      if (tp_start && !prev_st) begin st_runs++; first_word = tp_iword; end
      prev_st = tp_start;
      err_cnt += int'(job_err);
      if (job_done) begin done_cnt++; done_cyc = cyc; done_precs.push_back(int'(tp_prec)); end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] wv(int tag, int idx);
    return 32'hA500_0000 | (32'(tag) << 16) | 32'(idx);
  endfunction

  task automatic clr_mon();
    ir_cnt = 0; st_cnt = 0; st_runs = 0; done_cnt = 0; err_cnt = 0;
    done_precs.delete();
  endtask

  task automatic push_job(int p, int b, int n);
    bit r; int g = 0;
    job_valid = 1; job_prec = 32'(p); job_baddr = 32'(b); job_nwords = 7'(n);
    do begin @(negedge clk); r = job_ready; @(posedge clk); #1; g++; end
    while (!r && g < 500);
    if (!r) chk("push_timeout", 0, 1);
    job_valid = 0;
  endtask

  task automatic feed(int n, bit gappy, int tag);
    int acc = 0, g = 0; bit ph = 0;
    while (acc < n && g < 3000) begin
      @(posedge clk); #1; g++;
      if (gappy) begin in_valid = in_ready && !ph; if (in_ready) ph = ~ph; end
      else in_valid = 1;
      in_word = wv(tag, acc);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
    end
    if (acc < n) chk("feed_timeout", acc, n);
    @(posedge clk); #1; in_valid = 0;
  endtask

  task automatic wait_dones(int target, int budget);
    int g = 0;
    while (done_cnt < target && g < budget) begin @(posedge clk); #1; g++; end
    chk("dones_reached", done_cnt >= target, 1);
  endtask

  initial begin
    int g, fall_cyc, b_cyc;
`ifdef TRANSPOSER_JOB_CTRL_PERF_EN
    int fs0;
`endif
    repeat (3) @(posedge clk); #1;
    chk("rst_job_ready", job_ready, 0);
    chk("rst_tp_start", tp_start, 0);
    chk("rst_pending", jobs_pending, 0);
    chk("rst_tp_prec", tp_prec, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_ready", job_ready, 1);

    // single 64-word job
    clr_mon();
    push_job(6, 'h10, 64);
    feed(64, 0, 1);
    wait_dones(1, 300);
    repeat (3) @(posedge clk); #1;
    chk("t1_inready_cyc", ir_cnt, 64);
    chk("t1_start_cyc", st_cnt, 64);
    chk("t1_start_runs", st_runs, 1);
    chk("t1_first_word", first_word, 32'hA501_0000);
    chk("t1_prec", tp_prec, 6);
    chk("t1_baddr", tp_baddr, 'h10);
    chk("t1_dones", done_cnt, 1);

    // gappy input, 8 words
    clr_mon();
`ifdef TRANSPOSER_JOB_CTRL_PERF_EN
    fs0 = int'(perf_fill_stall);
`endif
    push_job(3, 'h44, 8);
    feed(8, 1, 2);
    wait_dones(1, 100);
    chk("t2_fill_cyc", ir_cnt, 15);
    chk("t2_start_cyc", st_cnt, 8);
    chk("t2_start_runs", st_runs, 1);
`ifdef TRANSPOSER_JOB_CTRL_PERF_EN
    chk("t2_fill_stall", int'(perf_fill_stall) - fs0, 7);
`endif

    // illegal descriptors
    clr_mon();
    push_job(0, 1, 5);
    push_job(9, 1, 5);
    push_job(3, 1, 0);
    push_job(3, 1, 65);
    repeat (4) @(posedge clk); #1;
    chk("t3_errs", err_cnt, 4);
    chk("t3_starts", st_cnt, 0);
    chk("t3_pending", jobs_pending, 0);

    // long drain with backlog pushed meanwhile
    clr_mon();
    tp_busy = 1;
    push_job(2, 'h20, 4);
    feed(4, 0, 5);
    g = 0;
    while (!(st_cnt == 4 && !tp_start) && g < 200) begin @(posedge clk); #1; g++; end
    chk("t4_burst_end", st_cnt, 4);
    fall_cyc = cyc;
    push_job(1, 'h100, 1);
    push_job(3, 'h200, 2);
    push_job(5, 'h300, 64);
    push_job(7, 'h400, 3);
    chk("t4_ready_full", job_ready, 0);
    chk("t4_pending5", jobs_pending, 5);
    while (cyc - fall_cyc < 100) begin @(posedge clk); #1; end
    chk("t4_no_early_done", done_cnt, 0);
    tp_busy = 0; b_cyc = cyc;
    repeat (5) @(posedge clk); #1;
    chk("t4_one_done", done_cnt, 1);
    chk("t4_done_lat", done_cyc - b_cyc, 1);
`ifdef TRANSPOSER_JOB_CTRL_PERF_EN
    chk("t4_perf_drain", perf_drain_cyc >= 100, 1);
`endif
    feed(70, 0, 6);
    wait_dones(5, 600);
    chk("t4_order_n", done_precs.size(), 5);
    if (done_precs.size() == 5) begin
      chk("t4_order0", done_precs[0], 2);
      chk("t4_order1", done_precs[1], 1);
      chk("t4_order2", done_precs[2], 3);
      chk("t4_order3", done_precs[3], 5);
      chk("t4_order4", done_precs[4], 7);
    end
    chk("t4_pending0", jobs_pending, 0);

    // reset in the middle of a burst
    clr_mon();
    push_job(4, 'h30, 64);
    push_job(8, 'h34, 2);
    feed(64, 0, 7);
    g = 0;
    while (st_cnt < 21 && g < 200) begin @(posedge clk); #1; g++; end
    chk("t5_reach_w20", st_cnt >= 21, 1);
    rst = 1; #1;
    chk("t5_start_low", tp_start, 0);
    chk("t5_pending", jobs_pending, 0);
    repeat (2) @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("t5_no_done", done_cnt, 0);
    push_job(3, 'h50, 3);
    feed(3, 0, 8);
    wait_dones(1, 100);
    repeat (2) @(posedge clk); #1;
    chk("t5_next_done", done_cnt, 1);
    chk("t5_next_prec", tp_prec, 3);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/transposer_job_ctrl.md
Name: transposer_job_ctrl

Overview:
- Job sequencer in front of data_transposer.
- Accepts job descriptors (precision, MVU base address, word count) and a word stream over valid/ready.
- Buffers each job's words completely, then drives start/prec/baddr/iword into the transposer as one unbroken burst.
- Waits for transposer busy to clear, then reports completion; the transposer therefore never sees a data bubble.

Parameters:
- XLEN, 32, input word width (matches transposer iword).
- MVU_ADDR_LEN, 15, MVU base address width.
- MAX_DATA_PREC, 8, largest legal precision.
- WBUF_DEPTH, 64, word buffer depth; max words per job.
- JOBQ_DEPTH, 4, descriptor queue depth (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- job_valid  in  1  descriptor valid.
- job_ready  out  1  descriptor queue not full.
- job_prec  in  32  precision, legal 1..MAX_DATA_PREC.
- job_baddr  in  32  MVU base address.
- job_nwords  in  $clog2(WBUF_DEPTH)+1  words in job, legal 1..WBUF_DEPTH.
- in_valid  in  1  word valid.
- in_ready  out  1  word accepted this cycle.
- in_word  in  XLEN  word data.
- tp_prec  out  32  to transposer prec.
- tp_baddr  out  32  to transposer baddr.
- tp_iword  out  XLEN  to transposer iword.
- tp_start  out  1  to transposer start.
- tp_busy  in  1  from transposer busy.
- job_done  out  1  one-cycle pulse per completed job.
- job_err  out  1  one-cycle pulse on rejected descriptor.
- jobs_pending  out  $clog2(JOBQ_DEPTH)+1  queued descriptors, plus 1 if a job is active.

Behaviour:
- Reset (async, any state): all outputs 0; FSM to IDLE; queue and buffer emptied; in-flight job discarded without a done pulse.
- Descriptor accept: a descriptor is pushed when job_valid && job_ready.
- Descriptor check: a descriptor with prec==0, prec>MAX_DATA_PREC, nwords==0 or nwords>WBUF_DEPTH is consumed but not queued. job_err pulses the next cycle.
- FSM states: IDLE, FILL, STREAM, DRAIN, DONE.
- IDLE -> FILL: when the queue is non-empty, pop the head and latch prec, baddr and nwords. tp_prec and tp_baddr update that cycle and are held until DONE.
- FILL:
  - in_ready=1 while buffered count < nwords.
  - A word is written on in_valid && in_ready.
  - When count==nwords, go to STREAM the next cycle.
  - in_ready=0 in every state other than FILL.
- STREAM:
  - tp_start=1 every cycle.
  - tp_iword = buffer[k], k=0..nwords-1, one word per cycle, no gaps.
  - The first word appears the cycle after the last FILL accept.
  - After word nwords-1, tp_start drops and the FSM goes to DRAIN.
- DRAIN: wait for tp_busy==0, sampled no earlier than 2 cycles after tp_start falls (tolerates one-cycle busy assertion lag). Then go to DONE.
- DONE: job_done=1 for one cycle, then IDLE. The next queued job can enter FILL the cycle after DONE.
- Simultaneous events:
  - A push and a pop in the same cycle are both honoured.
  - job_ready reflects the pre-pop occupancy (no combinational ready-through).
- Back-to-back operation: new descriptors may be pushed during any state. Words for the next job are not accepted until its FILL.
- tp_busy high in IDLE or FILL: ignored.
- tp_busy stuck high: DRAIN waits indefinitely; no timeout.
- Counters use $clog2(WBUF_DEPTH)+1 bits. Buffer index wraps to 0 at the start of each job.

Optional Feature:
- Macro: TRANSPOSER_JOB_CTRL_PERF_EN.
- When defined, add outputs:
  - perf_fill_stall [31:0]: counts FILL cycles with in_valid==0.
  - perf_drain_cyc [31:0]: counts DRAIN cycles.
  - Both saturate at all-ones and clear on rst.
- When undefined, neither the ports nor the logic exist, and behaviour is otherwise identical.

Decomposition:
- Package transposer_job_ctrl_pkg holds:
  - job_desc_t struct (prec, baddr, nwords);
  - tjc_state_e enum;
  - desc_legal() function.
- Sub-module transposer_job_fifo: synchronous FIFO of job_desc_t, depth JOBQ_DEPTH, with push/pop/full/empty/count.
- The word buffer is an inline register array.

Test Plan:
- Single job, prec=6, baddr=0x10, nwords=64, in_valid always high:
  - in_ready high for exactly 64 cycles;
  - tp_start high for exactly 64 consecutive cycles starting the cycle after the last accept;
  - tp_iword matches the input order; tp_prec=6, tp_baddr=0x10;
  - after tp_busy falls, exactly one job_done pulse.
- Gappy input, nwords=8, in_valid toggling 1010...:
  - FILL takes 15 cycles;
  - the STREAM burst is still 8 contiguous words, with no start gaps.
- Four descriptors pushed back-to-back (nwords 1, 2, 64, 3):
  - job_ready drops after the 4th until the first pop;
  - four ordered job_done pulses; jobs_pending counts 4 down to 0.
- Illegal descriptors (prec=0, prec=9, nwords=0, nwords=65):
  - four job_err pulses; no queue entry, no tp_start, jobs_pending stays 0.
- rst asserted mid-STREAM (after word 20 of 64):
  - tp_start=0 immediately; no job_done; queue empty;
  - the next legal job runs normally.
- tp_busy held high 100 cycles after the burst:
  - FSM stays in DRAIN; job_done fires exactly once, 1 cycle after busy falls;
  - with TRANSPOSER_JOB_CTRL_PERF_EN defined, perf_drain_cyc ≥ 100.
